// File: rtl/alu_cp_host.sv
// Host-side controller for the 4-bit ALU coprocessor (ADDI): owns a 16x4 register
// file, sequences the coprocessor handshake and writes the returned sum back.
module alu_cp_host #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_imm,
    input  logic [3:0] cmd_src,
    input  logic [3:0] cmd_dst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [3:0] rd_data,
    output logic [3:0] cp_opcode,
    output logic [3:0] cp_mio,
    input  logic [3:0] cp_bus_req,
    input  logic [3:0] cp_bus_in,
    input  logic       cp_carry,
    input  logic       cp_done,
    output logic [3:0] cp_bus_out,
    output logic       cp_bus_oe,
    output logic       cp_oe_n,
    output logic       rsp_valid,
    output logic [3:0] rsp_sum,
    output logic       rsp_carry,
    output logic       rsp_err
);

    localparam int unsigned NREG = 16;
    localparam int unsigned CW   = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_ADDI    = 4'd1;
    localparam logic [3:0] REQ_FETCH  = 4'b0011;
    localparam logic [3:0] REQ_SUPPLY = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FETCH,
        SUPPLY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    regs [NREG];
    logic [3:0]    dst;
    logic [CW-1:0] cnt;

    logic progress_c;
    logic abort_c;
    logic wb_en_c;

    assign cmd_ready = (state == IDLE);
    assign rd_data   = regs[rd_addr];

    // Event that ends each wait state; a done arriving on the last cycle beats the timeout.
    always_comb begin
        progress_c = 1'b0;
        case (state)
            ISSUE:     progress_c = (cp_bus_req == REQ_FETCH);
            FETCH:     progress_c = (cp_bus_req == REQ_SUPPLY);
            WAIT_DONE: progress_c = cp_done;
            default:   progress_c = 1'b0;
        endcase
    end

    assign abort_c = ((state == ISSUE) || (state == FETCH) || (state == WAIT_DONE))
                     && !progress_c && (cnt == CW'(TIMEOUT - 1));
    assign wb_en_c = (state == WAIT_DONE) && cp_done;

    // Writeback is applied last so it wins a same-address collision with wr_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (wb_en_c) begin
                regs[dst] <= cp_bus_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dst        <= '0;
            cnt        <= '0;
            cp_opcode  <= '0;
            cp_mio     <= '0;
            cp_bus_out <= '0;
            cp_bus_oe  <= 1'b0;
            cp_oe_n    <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (abort_c) begin
                cp_opcode <= '0;
                cp_bus_oe <= 1'b0;
                cp_oe_n   <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_sum   <= '0;
                rsp_carry <= 1'b0;
                rsp_valid <= 1'b1;
                cnt       <= '0;
                state     <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            dst        <= cmd_dst;
                            cp_opcode  <= OP_ADDI;
                            cp_mio     <= cmd_imm;
                            cp_bus_out <= regs[cmd_src];
                            cp_bus_oe  <= 1'b1;
                            cp_oe_n    <= 1'b0;
                            cnt        <= '0;
                            state      <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (progress_c) begin
                            cnt   <= '0;
                            state <= FETCH;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    FETCH: begin
                        if (progress_c) begin
                            cnt   <= '0;
                            state <= SUPPLY;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    // Opcode drops on the second edge so the coprocessor sees it low right after done.
                    SUPPLY: begin
                        if (cnt == CW'(1)) begin
                            cp_opcode <= '0;
                            cnt       <= '0;
                            state     <= WAIT_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    WAIT_DONE: begin
                        if (progress_c) begin
                            rsp_sum   <= cp_bus_in;
                            rsp_carry <= cp_carry;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            cp_bus_oe <= 1'b0;
                            cp_oe_n   <= 1'b1;
                            cnt       <= '0;
                            state     <= RESP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RESP: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_cp_host.sv
// Bench for alu_cp_host: coprocessor model, directed commands, scoreboard-checked responses.
module tb_alu_cp_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_imm, cmd_src, cmd_dst;
    logic       wr_en;
    logic [3:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0] cp_opcode, cp_mio, cp_bus_req, cp_bus_in, cp_bus_out;
    logic       cp_carry, cp_done, cp_bus_oe, cp_oe_n;
    logic       rsp_valid, rsp_carry, rsp_err;
    logic [3:0] rsp_sum;

    alu_cp_host #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_imm(cmd_imm), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cp_opcode(cp_opcode), .cp_mio(cp_mio),
        .cp_bus_req(cp_bus_req), .cp_bus_in(cp_bus_in),
        .cp_carry(cp_carry), .cp_done(cp_done),
        .cp_bus_out(cp_bus_out), .cp_bus_oe(cp_bus_oe), .cp_oe_n(cp_oe_n),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0] sum;
        logic       carry;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb_q[$];

    // Coprocessor model controls
    int m_d       = 0;
    bit m_hang    = 1'b0;
    bit stale_pre = 1'b0;
    bit m_busy    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Cycle-accurate coprocessor: starts on opcode 1, requests 0011 then 0001, returns done.
    initial begin
        int        mcnt;
        logic [4:0] s;
        mcnt = 0;
        s    = '0;
        cp_bus_req = '0; cp_bus_in = '0; cp_carry = 1'b0; cp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 1'b0;
                cp_bus_req = '0; cp_bus_in = '0; cp_carry = 1'b0; cp_done = 1'b0;
            end else if (!m_busy) begin
                cp_bus_req = stale_pre ? 4'b0001 : 4'b0000;
                if (cp_opcode == 4'd1) begin
                    m_busy = 1'b1;
                    mcnt   = 0;
                    s      = 5'(cp_mio) + 5'(cp_bus_out);
                end
            end else begin
                mcnt++;
                if (m_hang) begin
                    if (mcnt == 7) check("to_opcode_held", int'(cp_opcode), 1);
                    if (mcnt == 8) begin
                        check("to_opcode_cleared", int'(cp_opcode), 0);
                        check("to_bus_oe_cleared", int'(cp_bus_oe), 0);
                        check("to_oe_n_set", int'(cp_oe_n), 1);
                        m_busy = 1'b0;
                    end
                end else if (mcnt == 1 + m_d) begin
                    cp_bus_req = 4'b0011;
                end else if (mcnt == 2 + m_d) begin
                    cp_bus_req = 4'b0001;
                end else if (mcnt == 3 + m_d) begin
                    cp_bus_req = 4'b0000;
                end else if (mcnt == 4 + m_d) begin
                    check("opcode_at_done_edge", int'(cp_opcode), 1);
                    check("oe_n_low_in_flight", int'(cp_oe_n), 0);
                end else if (mcnt == 5 + m_d) begin
                    check("opcode_after_done_edge", int'(cp_opcode), 0);
                    cp_done   = 1'b1;
                    cp_bus_in = s[3:0];
                    cp_carry  = s[4];
                end else if (mcnt == 6 + m_d) begin
                    cp_done = 1'b0;
                    check("opcode_no_restart", int'(cp_opcode), 0);
                    check("oe_n_released", int'(cp_oe_n), 1);
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected response whenever rsp_valid is seen.
    initial begin
        exp_t e;
        bit   chk_low;
        chk_low = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_low) begin
                check("rsp_valid_one_cycle", int'(rsp_valid), 0);
                chk_low = 1'b0;
            end else if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", int'(rsp_valid), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_sum", int'(rsp_sum), int'(e.sum));
                    check("rsp_carry", int'(rsp_carry), int'(e.carry));
                    check("rsp_err", int'(rsp_err), int'(e.err));
                    check("rsp_latency", cyc - e.acc, e.lat);
                end
                chk_low = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic reg_write(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_check(input string name, input logic [3:0] a, input int exp);
        rd_addr = a;
        #1;
        check(name, int'(rd_data), exp);
    endtask

    // Returns at the negedge right after the accept edge.
    task automatic issue(input logic [3:0] imm, input logic [3:0] src, input logic [3:0] dst,
                         input bit track, input logic [3:0] esum, input logic ecarry,
                         input logic eerr, input int elat);
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_imm = imm; cmd_src = src; cmd_dst = dst;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (track) begin
            e.sum = esum; e.carry = ecarry; e.err = eerr; e.lat = elat; e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 40);
        check("idle_within_bound", int'(cmd_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check({tag, "_cp_opcode"}, int'(cp_opcode), 0);
        check({tag, "_cp_mio"}, int'(cp_mio), 0);
        check({tag, "_cp_bus_out"}, int'(cp_bus_out), 0);
        check({tag, "_cp_bus_oe"}, int'(cp_bus_oe), 0);
        check({tag, "_cp_oe_n"}, int'(cp_oe_n), 1);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_sum"}, int'(rsp_sum), 0);
        check({tag, "_rsp_carry"}, int'(rsp_carry), 0);
        check({tag, "_rsp_err"}, int'(rsp_err), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_imm = '0; cmd_src = '0; cmd_dst = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Basic add: 5 + 9 = 14 into reg7
        reg_write(4'd2, 4'd5);
        issue(4'd9, 4'd2, 4'd7, 1'b1, 4'd14, 1'b0, 1'b0, 6);
        check("bus_out_operand", int'(cp_bus_out), 5);
        check("mio_imm", int'(cp_mio), 9);
        wait_idle();
        reg_check("basic_reg7", 4'd7, 14);

        // Reset mid-SUPPLY
        issue(4'd9, 4'd2, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        for (int i = 0; i < 16; i++) begin
            reg_check("midrst_reg_zero", 4'(i), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Carry wrap: 1 + 15 = 16 -> sum 0, carry 1, into reg0
        reg_write(4'd0, 4'd1);
        issue(4'd15, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 6);
        wait_idle();
        reg_check("carry_reg0", 4'd0, 0);

        // Collision: wr_en data 3 to dst on writeback cycle, sum 10 wins
        reg_write(4'd2, 4'd5);
        issue(4'd5, 4'd2, 4'd4, 1'b1, 4'd10, 1'b0, 1'b0, 6);
        repeat (5) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 4'd3;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle();
        reg_check("collision_same_addr", 4'd4, 10);

        // Collision on different addresses: both writes land
        issue(4'd5, 4'd2, 4'd6, 1'b1, 4'd10, 1'b0, 1'b0, 6);
        repeat (5) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 4'd12;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle();
        reg_check("collision_wb_lands", 4'd6, 10);
        reg_check("collision_ext_lands", 4'd9, 12);

        // Timeout: coprocessor never requests, dst untouched
        reg_write(4'd5, 4'd6);
        m_hang = 1'b1;
        issue(4'd3, 4'd2, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 8);
        wait_idle();
        m_hang = 1'b0;
        reg_check("timeout_dst_kept", 4'd5, 6);

        // Stale 0001 before accept is ignored; 5 + 2 = 7 into reg8
        @(negedge clk);
        stale_pre = 1'b1;
        m_d = 2;
        @(negedge clk);
        issue(4'd2, 4'd2, 4'd8, 1'b1, 4'd7, 1'b0, 1'b0, 8);
        wait_idle();
        stale_pre = 1'b0;
        m_d = 0;
        reg_check("stale_reg8", 4'd8, 7);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_cp_host.md
# alu_cp_host

Host-side controller for the 4-bit ALU coprocessor (ADDI opcode 1). It owns a 16x4 register file and accepts add commands (immediate + source register + destination register). It drives the coprocessor opcode and immediate pins and answers the coprocessor's bus requests with the source register value. It captures the sum and carry when the coprocessor signals done, then writes the sum back to the destination register.

## Interface
- TIMEOUT, 8: max cycles spent in any single wait state before aborting
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_imm  in  4  immediate operand
- cmd_src  in  4  source register index
- cmd_dst  in  4  destination register index
- wr_en  in  1  external register-file write
- wr_addr  in  4  external write index
- wr_data  in  4  external write data
- rd_addr  in  4  debug read index
- rd_data  out  4  combinational read of reg[rd_addr]
- cp_opcode  out  4  to coprocessor opcode pins (registered)
- cp_mio  out  4  to coprocessor immediate pins (registered)
- cp_bus_req  in  4  coprocessor request code
- cp_bus_in  in  4  coprocessor result bus
- cp_carry  in  1  coprocessor carry
- cp_done  in  1  coprocessor done
- cp_bus_out  out  4  operand driven to coprocessor bus
- cp_bus_oe  out  1  cp_bus_out valid/driven
- cp_oe_n  out  1  low = coprocessor may drive result
- rsp_valid  out  1  one-cycle response strobe
- rsp_sum  out  4  captured sum
- rsp_carry  out  1  captured carry
- rsp_err  out  1  timeout flag, valid with rsp_valid

## Operation
- States: IDLE, ISSUE, FETCH, SUPPLY, WAIT_DONE, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch src value reg[cmd_src] into operand and latch dst. Set cp_opcode<=1, cp_mio<=cmd_imm, cp_bus_out<=operand, cp_bus_oe<=1, cp_oe_n<=0. Go to ISSUE.
- ISSUE: wait for cp_bus_req==4'b0011 and go to FETCH. A stale 4'b0001 from the previous op is ignored.
- FETCH: wait for cp_bus_req==4'b0001 and go to SUPPLY with sub-counter=0.
- SUPPLY: counter increments each cycle. At the 2nd edge in SUPPLY, set cp_opcode<=0 and go to WAIT_DONE. The opcode must read 1 at the coprocessor's done edge and 0 on the following edge.
- WAIT_DONE: on cp_done==1:
  - rsp_sum<=cp_bus_in, rsp_carry<=cp_carry, rsp_err<=0.
  - Write rsp_sum into reg[dst].
  - Clear cp_bus_oe, set cp_oe_n<=1, go to RESP.
- Timeout: the wait counter resets on every state entry. If ISSUE, FETCH or WAIT_DONE lasts TIMEOUT cycles:
  - cp_opcode<=0, cp_bus_oe<=0, cp_oe_n<=1.
  - rsp_err<=1, rsp_sum/rsp_carry<=0, no writeback, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_sum, rsp_carry and rsp_err hold until the next response.
- Sum is a 5-bit add done by the coprocessor. The controller does no arithmetic and takes the sum/carry values as given.
- Register file writes:
  - External wr_en may write in any state.
  - If writeback and wr_en hit the same cycle, writeback wins on a same-address collision. On different addresses, both writes occur.
  - The source operand is snapshotted at accept, so later writes to src do not affect an in-flight op.
- Reset (any state, including mid-operation):
  - State IDLE.
  - All 16 registers = 0.
  - cp_opcode=0, cp_mio=0, cp_bus_out=0, cp_bus_oe=0, cp_oe_n=1.
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_err=0, counters=0.
- Unused coprocessor request codes are ignored in all states.

## Timing
- Accept edge T0: cp_opcode=1 and the operand are on the pins from T0.
- Coprocessor edges E0..E4 = T1..T5:
  - 0011 seen at T2, 0001 seen at T3 (enter SUPPLY).
  - cp_opcode<=0 at T5, done sampled at T6.
- rsp_valid is high in the cycle after T6. cmd_ready returns in the cycle after that.
- Nominal command-to-response latency: 6 cycles. Back-to-back throughput: one command per 8 cycles.
- cp_bus_out is stable from T0 through capture.
- cp_oe_n is low from T0 until capture.

## Test plan
- Reset: assert rst mid-SUPPLY → next cycle all outputs at reset values, cmd_ready=1, rd_data=0 for every index.
- Basic add: preload reg2=5; cmd imm=9 src=2 dst=7 with a cycle-accurate coprocessor model → rsp_sum=14, rsp_carry=0, rsp_err=0, rsp_valid 6 cycles after accept, reg7=14.
- Carry wrap: reg0=1, imm=15, dst=0 → rsp_sum=0, rsp_carry=1, reg0=0. cp_opcode falls exactly at the coprocessor's done edge, and the coprocessor does not restart.
- Timeout: model never raises 0011 → after TIMEOUT=8 cycles, rsp_err=1, rsp_sum=0, cp_opcode=0, destination register unchanged.
- Collision: wr_en to dst with data 3 on the writeback cycle of a sum of 10 → reg=10. wr_en to another address the same cycle → that write also lands.
- Stale request: cp_bus_req held at 0001 before accept → FSM stays in ISSUE until 0011 appears, with correct result after.
